// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: reads the 11 RTC time/date/timer registers over a multiplexed address/data bus.
module rtc_read_sequencer #(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       cap_valid,
  output logic [3:0] cap_index,
  output logic [7:0] cap_data,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_HOLD, DATA, GAP, FIN} state_t;
  localparam logic [7:0] LAST = 8'(T_PHASE - 1);
  state_t     state;
  logic [7:0] cnt;
  logic [3:0] idx;
  logic       last;
  assign last = cnt == LAST;
  function automatic logic [7:0] addr_of(input logic [3:0] i);
    return i < 4'd8 ? 8'h21 + {4'h0, i} : 8'h39 + {4'h0, i};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      a_d       <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      cap_valid <= 1'b0;
      cap_index <= '0;
      cap_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        ad_oe <= 1'b0;
        a_d   <= 1'b0;
        cs_n  <= 1'b1;
        rd_n  <= 1'b1;
        wr_n  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        cnt <= last || state == IDLE || state == FIN ? 8'd0 : cnt + 8'd1;
        case (state)
          IDLE: if (start) begin
            state  <= ADDR;
            idx    <= '0;
            ad_out <= addr_of(4'd0);
            ad_oe  <= 1'b1;
            cs_n   <= 1'b0;
            wr_n   <= 1'b0;
            busy   <= 1'b1;
          end
          ADDR: if (last) begin
            state <= ADDR_HOLD;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
          end
          // ad_oe drops on the same edge rd_n falls, so the two never overlap
          ADDR_HOLD: if (last) begin
            state <= DATA;
            ad_oe <= 1'b0;
            a_d   <= 1'b1;
            cs_n  <= 1'b0;
            rd_n  <= 1'b0;
          end
          DATA: if (last) begin
            state     <= GAP;
            cap_data  <= ad_in;
            cap_index <= idx;
            cap_valid <= 1'b1;
            a_d       <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
          end
          GAP: if (last) begin
            if (idx == 4'd10) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state  <= ADDR;
              idx    <= idx + 4'd1;
              ad_out <= addr_of(idx + 4'd1);
              ad_oe  <= 1'b1;
              cs_n   <= 1'b0;
              wr_n   <= 1'b0;
            end
          end
          FIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb_rtc_read_sequencer: two DUTs (T_PHASE 4 and 1) checked every cycle against a burst-timeline model.
module tb_rtc_read_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0;
  bit   dir = 1'b0;
  int   cyc = 0;
  int   errors = 0, checks = 0;
  byte unsigned tbl [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int TP = g == 0 ? 4 : 1;
    logic [7:0] ad_in = 8'h00, ad_out, cap_data;
    logic       ad_oe, a_d, cs_n, rd_n, wr_n, cap_valid, busy, done;
    logic [3:0] cap_index;
    rtc_read_sequencer #(.T_PHASE(TP)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .ad_in(ad_in),
      .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
      .cap_valid(cap_valid), .cap_index(cap_index), .cap_data(cap_data), .busy(busy), .done(done)
    );
    // mode 0 idle, 1 burst (t = cycles since first ADDR cycle), 2 fin
    int mode = 0, t = 0, m_cidx = 0, m_cdata = 0;
    bit m_cv = 0, m_done = 0, m_rst = 1;
    int done_cyc = -1;
    int capq [$];
    int aoq [$];
    bit prev_oe = 0;
    always @(posedge clk) begin
      if (reset) begin
        mode = 0; t = 0; m_cidx = 0; m_cdata = 0; m_cv = 0; m_done = 0; m_rst = 1;
      end else begin
        m_cv = 0; m_done = 0;
        if (abort) mode = 0;
        else if (mode == 0) begin
          if (start) begin mode = 1; t = 0; m_rst = 0; end
        end else if (mode == 2) mode = 0;
        else begin
          if (t % (4 * TP) == 3 * TP - 1) begin
            m_cdata = ad_in; m_cidx = t / (4 * TP); m_cv = 1;
          end
          if (t == 44 * TP - 1) begin mode = 2; m_done = 1; end
          else t++;
        end
      end
    end
    always @(negedge clk) begin
      int ph, r, ev;
      if (cyc > 0) begin
        ph = mode == 1 ? (t % (4 * TP)) / TP : 3;
        r  = t / (4 * TP);
        ev = ph == 0 ? 5'b00101 : ph == 1 ? 5'b01111 : ph == 2 ? 5'b10010 : 5'b01110;
        chk($sformatf("u%0d strobes{a_d,cs_n,rd_n,wr_n,oe}", g), {a_d, cs_n, rd_n, wr_n, ad_oe}, ev);
        if (ad_oe) chk($sformatf("u%0d ad_out", g), ad_out, tbl[r]);
        if (m_rst) chk($sformatf("u%0d ad_out_reset", g), ad_out, 0);
        chk($sformatf("u%0d busy", g), busy, mode != 0);
        chk($sformatf("u%0d done", g), done, m_done);
        chk($sformatf("u%0d cap_valid", g), cap_valid, m_cv);
        chk($sformatf("u%0d cap_index", g), cap_index, m_cidx);
        chk($sformatf("u%0d cap_data", g), cap_data, m_cdata);
        chk($sformatf("u%0d oe_with_rd", g), ad_oe & ~rd_n, 0);
        if (done) done_cyc = cyc;
        if (cap_valid && dir) capq.push_back({cap_index, cap_data});
        if (ad_oe && !prev_oe && dir) aoq.push_back(ad_out);
        prev_oe = ad_oe;
      end
      ad_in = dir ? 8'h50 + 8'(t / (4 * TP)) : 8'($urandom);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int d0, n;
    int lit [11] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h41, 'h42, 'h43};
    tick(3);
    chk("reset busy", u[0].busy, 0);
    chk("reset cs_n", u[0].cs_n, 1);
    chk("reset cap_data", u[0].cap_data, 0);
    reset = 0;
    tick(2);
    // single burst with ad_in = 0x50 + index
    dir = 1;
    u[0].done_cyc = -1; u[1].done_cyc = -1;
    start = 1; d0 = cyc;
    tick(1);
    start = 0;
    n = 0;
    while (n < 300 && (u[0].done_cyc < 0 || u[1].done_cyc < 0)) begin tick(1); n++; end
    chk("done latency T4", u[0].done_cyc - d0, 177);
    chk("done latency T1", u[1].done_cyc - d0, 45);
    chk("cap count T4", u[0].capq.size(), 11);
    chk("cap count T1", u[1].capq.size(), 11);
    chk("ad_out seq count", u[0].aoq.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < u[0].capq.size()) chk($sformatf("cap T4 %0d", i), u[0].capq[i], (i << 8) | (8'h50 + i));
      if (i < u[1].capq.size()) chk($sformatf("cap T1 %0d", i), u[1].capq[i], (i << 8) | (8'h50 + i));
      if (i < u[0].aoq.size()) chk($sformatf("ad_out seq %0d", i), u[0].aoq[i], lit[i]);
    end
    dir = 0;
    tick(3);
    // abort wins over start in IDLE
    abort = 1; start = 1;
    tick(3);
    chk("abort+start busy T4", u[0].busy, 0);
    chk("abort+start busy T1", u[1].busy, 0);
    abort = 0; start = 0;
    tick(1);
    // start held: back-to-back bursts
    start = 1;
    tick(3 * 178 + 10);
    start = 0;
    n = 0;
    while (n < 400 && (u[0].busy || u[1].busy)) begin tick(1); n++; end
    chk("drain timeout", n < 400, 1);
    tick(2);
    // abort in DATA of index 5
    start = 1;
    tick(1);
    start = 0;
    n = 0;
    while (n < 200 && !(u[0].mode == 1 && u[0].t == 5 * 16 + 9)) begin tick(1); n++; end
    chk("reach data5", n < 200, 1);
    u[0].done_cyc = -1;
    abort = 1;
    tick(1);
    abort = 0;
    chk("abort busy", u[0].busy, 0);
    chk("abort cs_n", u[0].cs_n, 1);
    chk("abort rd_n", u[0].rd_n, 1);
    chk("abort oe", u[0].ad_oe, 0);
    tick(10);
    chk("abort no done", u[0].done_cyc, -1);
    start = 1;
    tick(1);
    start = 0;
    chk("restart ad_out", u[0].ad_out, 8'h21);
    chk("restart oe", u[0].ad_oe, 1);
    // reset in ADDR_HOLD of index 9, with start
    n = 0;
    while (n < 200 && !(u[0].mode == 1 && u[0].t == 9 * 16 + 5)) begin tick(1); n++; end
    chk("reach hold9", n < 200, 1);
    reset = 1; start = 1;
    tick(1);
    chk("rst9 strobes", {u[0].cs_n, u[0].rd_n, u[0].wr_n, u[0].a_d, u[0].ad_oe}, 5'b11100);
    chk("rst9 ad_out", u[0].ad_out, 0);
    chk("rst9 caps", {u[0].cap_valid, u[0].cap_index, u[0].cap_data}, 0);
    chk("rst9 busy/done", {u[0].busy, u[0].done}, 0);
    tick(1);
    reset = 0; start = 0;
    tick(1);
    chk("rst9 stays idle", u[0].busy, 0);
    // random traffic
    repeat (3000) begin
      start = $urandom % 8 == 0;
      abort = $urandom % 64 == 0;
      reset = $urandom % 256 == 0;
      tick(1);
    end
    start = 0; abort = 0; reset = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
